wvb_wr_addr_ctrl: RTL and testbench
===================================

WVB_WR_ADDR_CTRL -- requirements
Module: wvb_wr_addr_ctrl

Interface
REQ-001 Parameter P_ADR_WIDTH, default 12: buffer address width; depth = 2^P_ADR_WIDTH samples.
REQ-002 Parameter P_LTC_WIDTH, default 48: event timestamp width.
REQ-003 Parameter P_PRE_WIDTH, default 5: pretrigger-length field width.
REQ-004 clk  in  1  sole clock; one clock domain, all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 trig  in  1  trigger pulse, sampled each cycle.
REQ-007 trig_src  in  2  trigger source tag.
REQ-008 ltc  in  P_LTC_WIDTH  free-running timestamp.
REQ-009 pre_conf  in  P_PRE_WIDTH  pretrigger samples.
REQ-010 post_conf  in  P_ADR_WIDTH  post-trigger samples.
REQ-011 wvb_rd_addr  in  P_ADR_WIDTH  reader's current read address.
REQ-012 hdr_empty  in  1  header FIFO empty (no unread events).
REQ-013 hdr_full  in  1  header FIFO full.
REQ-014 wvb_wr_addr  out  P_ADR_WIDTH  sample write address.
REQ-015 wvb_wren  out  1  sample write enable.
REQ-016 hdr_wren  out  1  one-cycle header write strobe.
REQ-017 hdr_start_addr, hdr_stop_addr  out  P_ADR_WIDTH each  event first/last sample address.
REQ-018 hdr_evt_ltc  out  P_LTC_WIDTH; hdr_trig_src  out  2  latched event timestamp/source.
REQ-019 overflow  out  1  sticky: at least one trigger dropped for lack of space.
REQ-020 drop_cnt  out  16  dropped-trigger count, saturating at 0xFFFF.

Function
REQ-021 States IDLE, CAPTURE, HDR; IDLE after reset.
REQ-022 wvb_wren asserted whenever not stalled; wvb_wr_addr increments by 1 (mod 2^P_ADR_WIDTH) every cycle wvb_wren is high.
REQ-023 Stall: hdr_empty=0 and wvb_wr_addr+1 == wvb_rd_addr (mod); wvb_wren low, address held; hdr_empty=1 never stalls.
REQ-024 Free space F = (wvb_rd_addr - wvb_wr_addr - 1) mod 2^P_ADR_WIDTH if hdr_empty=0, else 2^P_ADR_WIDTH - 1.
REQ-025 Holdoff: trigger is eligible only in IDLE and only after at least pre_conf samples written since previous event's stop (or since reset); ineligible triggers are ignored silently.
REQ-026 Eligible trigger at cycle T with write address A: accepted iff not stalled, hdr_full=0, F >= post_conf+1; otherwise dropped: overflow<=1, drop_cnt+1.
REQ-027 On accept: latch start=A-pre_conf, stop=A+post_conf (mod), ltc, trig_src; next state CAPTURE if post_conf>0 else HDR.
REQ-028 CAPTURE writes A+1..A+post_conf in cycles T+1..T+post_conf, then HDR.
REQ-029 HDR: hdr_wren=1 for exactly one cycle (T+post_conf+1) with latched fields stable; return to IDLE; sample writing continues uninterrupted.
REQ-030 trig while in CAPTURE or HDR ignored, not counted.
REQ-031 Header fields hold value until next accepted trigger.

Reset
REQ-032 rst asynchronously forces: state IDLE, wvb_wr_addr 0, wvb_wren 0, hdr_wren 0, header outputs 0, overflow 0, drop_cnt 0, holdoff counter 0.
REQ-033 rst mid-CAPTURE aborts the event; no hdr_wren issued after rst deassertion for it.
REQ-034 wvb_wren first asserts the cycle after rst deasserts.

Structure
REQ-035 Shared package holds state encoding, L_WIDTH of header bundle, drop_cnt width and saturation constant.
REQ-036 One sub-module wvb_wr_free_space: combinational F and stall from wvb_wr_addr, wvb_rd_addr, hdr_empty.
REQ-037 Header outputs feed mDOM_wvb_hdr_bundle_3 fan-in outside this block.

Verification
REQ-038 pre=4, post=10, hdr_empty=1, trig at A=0x100 after 20 idle samples -> hdr_wren at T+11, start 0x0FC, stop 0x10A.
REQ-039 Trigger at A=0xFFE, pre=4, post=3 -> start 0xFFA, stop 0x001 (wrap), hdr_wren at T+4.
REQ-040 hdr_empty=0, wvb_rd_addr=0x050, trig at A=0x040, post=20 -> dropped, overflow=1, drop_cnt=1, no hdr_wren; writing stalls at 0x04F.
REQ-041 post=0, pre=0 -> start=stop=A, hdr_wren at T+1; trig at T+1 ignored, drop_cnt unchanged.
REQ-042 rst asserted at T+3 of post=10 capture -> outputs zero immediately, no hdr_wren thereafter, first trigger after reset needs pre_conf samples.

Source files
------------

// File: rtl/wvb_wr_addr_ctrl_pkg.sv
// ============================================================================
// wvb_wr_addr_ctrl_pkg : shared types/constants for the waveform write path
// Rev 1.0
// ============================================================================
`default_nettype none

package wvb_wr_addr_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_HDR     = 2'd2
  } wvb_state_t;

  // start + stop address, timestamp, trigger source at default widths
  localparam int L_WIDTH = 2*12 + 48 + 2;

  localparam int                        DROP_CNT_WIDTH = 16;
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_SAT   = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/wvb_wr_free_space.sv
// ============================================================================
// wvb_wr_free_space : free-slot count and write stall for the sample ring
// Rev 1.0
// ============================================================================
`default_nettype none

module wvb_wr_free_space #(
  parameter int P_ADR_WIDTH = 12
) (
  input  logic [P_ADR_WIDTH-1:0] wvb_wr_addr,
  input  logic [P_ADR_WIDTH-1:0] wvb_rd_addr,
  input  logic                   hdr_empty,
  output logic [P_ADR_WIDTH-1:0] free_space,
  output logic                   stall
);

  localparam logic [P_ADR_WIDTH-1:0] C_ONE = P_ADR_WIDTH'(1);

  // With no unread events the reader position is irrelevant: whole ring free.
  assign free_space = hdr_empty ? '1 : (wvb_rd_addr - wvb_wr_addr - C_ONE);
  assign stall      = ~hdr_empty && ((wvb_wr_addr + C_ONE) == wvb_rd_addr);

endmodule

`default_nettype wire

// File: rtl/wvb_wr_addr_ctrl.sv
// ============================================================================
// wvb_wr_addr_ctrl : waveform buffer write addressing, trigger capture, header
// Rev 1.0
// ============================================================================
`default_nettype none

module wvb_wr_addr_ctrl
  import wvb_wr_addr_ctrl_pkg::*;
#(
  parameter int P_ADR_WIDTH = 12,
  parameter int P_LTC_WIDTH = 48,
  parameter int P_PRE_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trig,
  input  logic [1:0]                trig_src,
  input  logic [P_LTC_WIDTH-1:0]    ltc,
  input  logic [P_PRE_WIDTH-1:0]    pre_conf,
  input  logic [P_ADR_WIDTH-1:0]    post_conf,
  input  logic [P_ADR_WIDTH-1:0]    wvb_rd_addr,
  input  logic                      hdr_empty,
  input  logic                      hdr_full,
  output logic [P_ADR_WIDTH-1:0]    wvb_wr_addr,
  output logic                      wvb_wren,
  output logic                      hdr_wren,
  output logic [P_ADR_WIDTH-1:0]    hdr_start_addr,
  output logic [P_ADR_WIDTH-1:0]    hdr_stop_addr,
  output logic [P_LTC_WIDTH-1:0]    hdr_evt_ltc,
  output logic [1:0]                hdr_trig_src,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  wvb_state_t             r_state, w_state_nxt;
  logic                   r_run;
  logic [P_PRE_WIDTH-1:0] r_holdoff;
  logic [P_ADR_WIDTH-1:0] w_free;
  logic                   w_stall;
  logic [P_ADR_WIDTH:0]   w_need;
  logic                   w_eligible, w_accept, w_drop;

  wvb_wr_free_space #(.P_ADR_WIDTH(P_ADR_WIDTH)) u_free_space (
    .wvb_wr_addr (wvb_wr_addr),
    .wvb_rd_addr (wvb_rd_addr),
    .hdr_empty   (hdr_empty),
    .free_space  (w_free),
    .stall       (w_stall)
  );

  // r_run delays the first write enable to the cycle after reset release
  assign wvb_wren = r_run & ~w_stall;
  assign hdr_wren = (r_state == S_HDR);
  assign w_need   = {1'b0, post_conf} + (P_ADR_WIDTH+1)'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_eligible  = trig && (r_state == S_IDLE) && (r_holdoff >= pre_conf);
    w_accept    = w_eligible && !w_stall && !hdr_full && ({1'b0, w_free} >= w_need);
    w_drop      = w_eligible && !w_accept;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_state_nxt = (post_conf == '0) ? S_HDR : S_CAPTURE;
      end
      S_CAPTURE: begin
        // Tracking the stop address keeps the capture correct across stalls
        if (wvb_wren && (wvb_wr_addr == hdr_stop_addr))
          w_state_nxt = S_HDR;
      end
      S_HDR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run          <= 1'b0;
      wvb_wr_addr    <= '0;
      r_holdoff      <= '0;
      hdr_start_addr <= '0;
      hdr_stop_addr  <= '0;
      hdr_evt_ltc    <= '0;
      hdr_trig_src   <= '0;
      overflow       <= 1'b0;
      drop_cnt       <= '0;
    end else begin
      r_run <= 1'b1;
      if (wvb_wren)
        wvb_wr_addr <= wvb_wr_addr + P_ADR_WIDTH'(1);

      // Holdoff counts samples written after the previous event's stop sample
      if (w_accept || (r_state == S_CAPTURE))
        r_holdoff <= '0;
      else if (wvb_wren && (r_holdoff != '1))
        r_holdoff <= r_holdoff + P_PRE_WIDTH'(1);

      if (w_accept) begin
        hdr_start_addr <= wvb_wr_addr - P_ADR_WIDTH'(pre_conf);
        hdr_stop_addr  <= wvb_wr_addr + post_conf;
        hdr_evt_ltc    <= ltc;
        hdr_trig_src   <= trig_src;
      end

      if (w_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != DROP_CNT_SAT)
          drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wvb_wr_addr_ctrl.sv
// ============================================================================
// tb_wvb_wr_addr_ctrl : directed self-checking bench for wvb_wr_addr_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wvb_wr_addr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic [1:0]  trig_src;
  logic [47:0] ltc;
  logic [4:0]  pre_conf;
  logic [11:0] post_conf;
  logic [11:0] wvb_rd_addr;
  logic        hdr_empty;
  logic        hdr_full;
  logic [11:0] wvb_wr_addr;
  logic        wvb_wren;
  logic        hdr_wren;
  logic [11:0] hdr_start_addr;
  logic [11:0] hdr_stop_addr;
  logic [47:0] hdr_evt_ltc;
  logic [1:0]  hdr_trig_src;
  logic        overflow;
  logic [15:0] drop_cnt;

  int n_pass  = 0;
  int n_total = 0;
  logic saw_hdr;

  always #5 clk = ~clk;

  wvb_wr_addr_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .trig           (trig),
    .trig_src       (trig_src),
    .ltc            (ltc),
    .pre_conf       (pre_conf),
    .post_conf      (post_conf),
    .wvb_rd_addr    (wvb_rd_addr),
    .hdr_empty      (hdr_empty),
    .hdr_full       (hdr_full),
    .wvb_wr_addr    (wvb_wr_addr),
    .wvb_wren       (wvb_wren),
    .hdr_wren       (hdr_wren),
    .hdr_start_addr (hdr_start_addr),
    .hdr_stop_addr  (hdr_stop_addr),
    .hdr_evt_ltc    (hdr_evt_ltc),
    .hdr_trig_src   (hdr_trig_src),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; trig = 1'b0; trig_src = 2'd0; ltc = '0;
    pre_conf = 5'd4; post_conf = 12'd10;
    wvb_rd_addr = 12'h000; hdr_empty = 1'b1; hdr_full = 1'b0;
    tick(); tick();

    // reset state
    check("rst_wr_addr", wvb_wr_addr, 0);
    check("rst_wren", wvb_wren, 0);
    check("rst_hdr_wren", hdr_wren, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_start", hdr_start_addr, 0);

    rst = 1'b0;
    tick();
    check("first_wren", wvb_wren, 1);
    check("first_addr", wvb_wr_addr, 0);

    // basic capture: pre=4 post=10 at A=0x100
    repeat (256) tick();
    check("t1_addr", wvb_wr_addr, 12'h100);
    trig = 1'b1; ltc = 48'h1234_5678_9ABC; trig_src = 2'd2;
    tick();
    trig = 1'b0;
    check("t1_start", hdr_start_addr, 12'h0FC);
    check("t1_stop", hdr_stop_addr, 12'h10A);
    repeat (9) tick();
    check("t1_hdr_early", hdr_wren, 0);
    tick();
    check("t1_hdr_wren", hdr_wren, 1);
    check("t1_ltc", hdr_evt_ltc, 48'h1234_5678_9ABC);
    check("t1_src", hdr_trig_src, 2'd2);
    tick();
    check("t1_hdr_once", hdr_wren, 0);
    check("t1_addr_after", wvb_wr_addr, 12'h10C);

    // trigger inside holdoff window is silently ignored
    trig = 1'b1; ltc = 48'hDEAD;
    tick();
    trig = 1'b0;
    tick();
    check("hold_drop_cnt", drop_cnt, 0);
    check("hold_overflow", overflow, 0);
    check("hold_start_kept", hdr_start_addr, 12'h0FC);
    check("hold_no_hdr", hdr_wren, 0);

    // wrap: A=0xFFE pre=4 post=3
    repeat (3824) tick();
    check("t2_addr", wvb_wr_addr, 12'hFFE);
    post_conf = 12'd3; trig = 1'b1; trig_src = 2'd1; ltc = 48'h0ABC;
    tick();
    trig = 1'b0;
    repeat (2) tick();
    check("t2_hdr_early", hdr_wren, 0);
    tick();
    check("t2_hdr_wren", hdr_wren, 1);
    check("t2_start", hdr_start_addr, 12'hFFA);
    check("t2_stop", hdr_stop_addr, 12'h001);
    check("t2_src", hdr_trig_src, 2'd1);
    tick();
    check("t2_addr_after", wvb_wr_addr, 12'h003);

    // pre=0 post=0: header on the very next cycle, retrigger ignored
    pre_conf = 5'd0; post_conf = 12'd0; trig = 1'b1;
    tick();
    check("t3_hdr_wren", hdr_wren, 1);
    check("t3_start", hdr_start_addr, 12'h003);
    check("t3_stop", hdr_stop_addr, 12'h003);
    tick();
    trig = 1'b0;
    check("t3_hdr_once", hdr_wren, 0);
    check("t3_drop_cnt", drop_cnt, 0);
    check("t3_start_kept", hdr_start_addr, 12'h003);

    // insufficient space: rd=0x050, trig at 0x040, post=20
    pre_conf = 5'd4; post_conf = 12'd20;
    hdr_empty = 1'b0; wvb_rd_addr = 12'h050;
    repeat (59) tick();
    check("t4_addr", wvb_wr_addr, 12'h040);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("t4_overflow", overflow, 1);
    check("t4_drop_cnt", drop_cnt, 1);
    check("t4_no_hdr", hdr_wren, 0);
    check("t4_start_kept", hdr_start_addr, 12'h003);
    repeat (20) tick();
    check("t4_stall_addr", wvb_wr_addr, 12'h04F);
    check("t4_stall_wren", wvb_wren, 0);

    // trigger while stalled, then while header FIFO full
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("stall_drop_cnt", drop_cnt, 2);
    hdr_empty = 1'b1;
    tick();
    check("unstall_addr", wvb_wr_addr, 12'h050);
    post_conf = 12'd10; hdr_full = 1'b1; trig = 1'b1;
    tick();
    trig = 1'b0; hdr_full = 1'b0;
    check("full_drop_cnt", drop_cnt, 3);
    check("full_no_hdr", hdr_wren, 0);

    // reset mid-capture aborts the event
    trig = 1'b1; ltc = 48'h0777; trig_src = 2'd3;
    tick();
    trig = 1'b0;
    check("t5_start", hdr_start_addr, 12'h04D);
    check("t5_stop", hdr_stop_addr, 12'h05B);
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_addr", wvb_wr_addr, 0);
    check("t5_rst_wren", wvb_wren, 0);
    check("t5_rst_stop", hdr_stop_addr, 0);
    check("t5_rst_ltc", hdr_evt_ltc, 0);
    check("t5_rst_src", hdr_trig_src, 0);
    check("t5_rst_overflow", overflow, 0);
    check("t5_rst_drop_cnt", drop_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t5_run_wren", wvb_wren, 1);

    // holdoff restarts: triggers at A=0..3 ignored, A=4 accepted
    saw_hdr = 1'b0;
    trig = 1'b1; ltc = 48'h0005; trig_src = 2'd0;
    for (int i = 0; i < 5; i++) begin
      saw_hdr = saw_hdr | hdr_wren;
      tick();
    end
    trig = 1'b0;
    check("t6_start", hdr_start_addr, 12'h000);
    check("t6_stop", hdr_stop_addr, 12'h00E);
    for (int i = 0; i < 9; i++) begin
      saw_hdr = saw_hdr | hdr_wren;
      tick();
    end
    check("t6_no_stale_hdr", saw_hdr, 0);
    tick();
    check("t6_hdr_wren", hdr_wren, 1);
    check("t6_ltc", hdr_evt_ltc, 48'h0005);
    check("t6_drop_cnt", drop_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
